request_latch: RTL and testbench

Upstream stage of the 4-bit priority encoder: captures request events into sticky pending bits, applies a programmable enable mask, and drives the encoder's D input. The consumer services the winning request by returning the encoder's ENC code as ACK_IDX with an ACK pulse. That clears the corresponding pending bit, so the next-highest request appears on the following cycle.

---
 rtl/request_latch_pkg.sv | 7 +
 rtl/req_edge_detect.sv | 17 +
 rtl/request_latch.sv | 51 +++++
 tb/tb_request_latch.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/request_latch_pkg.sv
// request_latch_pkg: shared defaults for the request latch slice
// Holds the default request count, the default ack-index width and the reset value of each mask bit.
package request_latch_pkg;
  localparam int   N_DEF    = 4;
  localparam int   IDXW_DEF = 2;
  localparam logic MASK_RST = 1'b1;
endpackage

// File: rtl/req_edge_detect.sv
// req_edge_detect: per-bit rising-edge pulse on the request lines
// Ports: clk, rst_n (sync, active-low), req[N] in, evt[N] out (req high now, low last cycle).
// Only needed by the REQUEST_LATCH_EDGE_EN build, so the body compiles only under that macro.
`ifdef REQUEST_LATCH_EDGE_EN
module req_edge_detect #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] evt
);
  logic [N-1:0] prev;
  always_ff @(posedge clk) prev <= !rst_n ? '0 : req;
  assign evt = req & ~prev;
endmodule
`endif

// File: rtl/request_latch.sv
// request_latch: sticky request capture with enable mask feeding a priority encoder
// Ports: clk, rst_n (sync, active-low), req[N], mask_we, mask_in[N], ack, ack_idx[IDXW],
//        ovf_clr[N] (W1C) in; d[N] = pend & mask, pend[N], ovf[N], any = |d out.
// Macro REQUEST_LATCH_EDGE_EN: rising-edge capture with overflow flags; otherwise level capture, ovf tied 0.
module request_latch
  import request_latch_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int IDXW = IDXW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            mask_we,
  input  logic [N-1:0]    mask_in,
  input  logic            ack,
  input  logic [IDXW-1:0] ack_idx,
  input  logic [N-1:0]    ovf_clr,
  output logic [N-1:0]    d,
  output logic [N-1:0]    pend,
  output logic [N-1:0]    ovf,
  output logic            any
);
  logic [N-1:0] mask, evt, clr;
  always_comb begin
    clr = '0;
    for (int i = 0; i < N; i++) clr[i] = ack && (int'(ack_idx) == i);
  end
`ifdef REQUEST_LATCH_EDGE_EN
  req_edge_detect #(.N(N)) u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .evt   (evt)
  );
  // an event on an already-pending bit overflows unless the same cycle acknowledges it; set beats clear
  always_ff @(posedge clk) ovf <= !rst_n ? '0 : (ovf & ~ovf_clr) | (evt & pend & ~clr);
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ^ovf_clr;
  assign evt = req;
  assign ovf = '0;
`endif
  // set wins over a same-cycle clear
  always_ff @(posedge clk) begin
    pend <= !rst_n ? '0 : (pend & ~clr) | evt;
    mask <= !rst_n ? {N{MASK_RST}} : mask_we ? mask_in : mask;
  end
  assign d   = pend & mask;
  assign any = |d;
endmodule

// File: tb/tb_request_latch.sv
// tb_request_latch: directed test plan plus randomized traffic against a behavioural model
module tb_request_latch;
  localparam int N    = 4;
  localparam int IDXW = 2;
`ifdef REQUEST_LATCH_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, mask_in, ovf_clr, d, pend, ovf;
  logic            mask_we, ack, any;
  logic [IDXW-1:0] ack_idx;
  int n_checks = 0;
  int n_fail   = 0;
  bit m_pend [N];
  bit m_mask [N];
  bit m_ovf  [N];
  bit m_prev [N];

  request_latch #(.N(N), .IDXW(IDXW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .mask_we (mask_we),
    .mask_in (mask_in),
    .ack     (ack),
    .ack_idx (ack_idx),
    .ovf_clr (ovf_clr),
    .d       (d),
    .pend    (pend),
    .ovf     (ovf),
    .any     (any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] vec(input bit a [N]);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = a[i];
    return v;
  endfunction

  function automatic logic [N-1:0] m_d();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i] && m_mask[i];
    return v;
  endfunction

  // apply the behavioural rules for one rising edge
  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      bit set, hit;
      set = EDGE ? (req[i] && !m_prev[i]) : req[i];
      hit = ack && (int'(ack_idx) == i);
      if (!rst_n) begin
        m_pend[i] = 0;
        m_ovf[i]  = 0;
        m_prev[i] = 0;
        m_mask[i] = 1;
      end else begin
        if (EDGE) begin
          if (set && m_pend[i] && !hit) m_ovf[i] = 1;
          else if (ovf_clr[i]) m_ovf[i] = 0;
        end
        if (set) m_pend[i] = 1;
        else if (hit) m_pend[i] = 0;
        m_prev[i] = req[i];
        if (mask_we) m_mask[i] = mask_in[i];
      end
    end
  endtask

  task automatic drive(input logic [N-1:0] r, input logic we, input logic [N-1:0] mi,
                       input logic a, input logic [IDXW-1:0] ai, input logic [N-1:0] oc);
    req = r; mask_we = we; mask_in = mi; ack = a; ack_idx = ai; ovf_clr = oc;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("pend", pend, vec(m_pend));
    check("d", d, m_d());
    check("ovf", ovf, vec(m_ovf));
    check("any", any, |m_d());
  endtask

  task automatic idle();
    drive('0, 0, '0, 0, '0, '0);
  endtask

  function automatic logic [IDXW-1:0] top_idx(input logic [N-1:0] v);
    logic [IDXW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (v[i]) r = IDXW'(i);
    return r;
  endfunction

  initial begin
    rst_n = 0;
    idle();
    #1;
    tick(); tick();
    check("rst_pend", pend, 4'b0000);
    check("rst_ovf", ovf, 4'b0000);
    check("rst_d", d, 4'b0000);
    check("rst_any", any, 1'b0);
    rst_n = 1;
    tick();
    drive(4'b0100, 0, '0, 0, '0, '0); tick();
    check("single_d", d, 4'b0100);
    check("single_any", any, 1'b1);
    drive('0, 0, '0, 1, 2'd2, '0); tick();
    check("single_ack", d, 4'b0000);
    drive(4'b1011, 0, '0, 0, '0, '0); tick();
    check("walk0", d, 4'b1011);
    drive('0, 0, '0, 1, 2'd3, '0); tick();
    check("walk1", d, 4'b0011);
    drive('0, 0, '0, 1, 2'd1, '0); tick();
    check("walk2", d, 4'b0001);
    drive('0, 0, '0, 1, 2'd0, '0); tick();
    check("walk3", d, 4'b0000);
    drive('0, 1, 4'b0111, 0, '0, '0); tick();
    drive(4'b1000, 0, '0, 0, '0, '0); tick();
    check("mask_pend", pend, 4'b1000);
    check("mask_d", d, 4'b0000);
    drive('0, 1, 4'b1111, 0, '0, '0); tick();
    check("unmask_d", d, 4'b1000);
    drive('0, 0, '0, 1, 2'd3, '0); tick();
    drive(4'b0010, 0, '0, 0, '0, '0); tick();
    idle(); tick();
    drive(4'b0010, 0, '0, 0, '0, '0); tick();
    check("ovf_set", ovf, EDGE ? 4'b0010 : 4'b0000);
    idle(); tick();
    drive(4'b0010, 0, '0, 1, 2'd1, '0); tick();
    check("ovf_ack_pend", pend[1], 1'b1);
    check("ovf_ack_ovf", ovf, EDGE ? 4'b0010 : 4'b0000);
    drive('0, 0, '0, 0, '0, 4'b0010); tick();
    check("ovf_clr", ovf, 4'b0000);
    drive('0, 0, '0, 1, 2'd1, '0); tick();
    for (int c = 0; c < 5; c++) begin
      drive(4'b0001, 0, '0, c == 1, 2'd0, '0);
      tick();
    end
    check("edge_vs_level", pend[0], EDGE ? 1'b0 : 1'b1);
    drive('0, 0, '0, 1, 2'd0, '0); tick();
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] r;
      r = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      drive(r, $urandom_range(0, 15) == 0, N'($urandom), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 3) == 0) ? IDXW'($urandom) : top_idx(d),
            ($urandom_range(0, 5) == 0) ? N'($urandom) : '0);
      rst_n = $urandom_range(0, 99) != 0;
      tick();
    end
    rst_n = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
